uart_rx_core: RTL and testbench
===============================

Name: uart_rx_core

Overview:
- Serial receive engine for the UART IP.
- Oversamples uart_rx using the 16x baud tick from the baud rate generator, then deframes start, data, optional parity and stop bits.
- Pushes each received character, with its error flags, into the RX FIFO through a one-cycle write strobe.
- The RX FIFO write port and the status register parity/frame error bits are driven from this block.

Parameters:
OVERSAMPLE, 16, baud ticks per bit; the mid-bit sample points below assume 16
SYNC_STAGES, 2, flip-flop stages in the uart_rx synchroniser (minimum 2)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
enable  input  1  receiver enable (control register); low aborts and holds the receiver idle
baud_tick  input  1  one-clk pulse at 16x the baud rate
uart_rx  input  1  asynchronous serial line, idle high
data_bits  input  2  00=5, 01=6, 10=7, 11=8 data bits
parity_mode  input  2  00=none, 01=even, 10=odd, 11=none
two_stop  input  1  1 = check two stop bits
rx_data  output  8  received character, LSB-aligned, zero-extended above data_bits
rx_valid  output  1  one-clk strobe; rx_data and the error flags are valid this cycle (FIFO write)
parity_error  output  1  parity mismatch on this character; qualified by rx_valid
frame_error  output  1  a stop bit was sampled 0; qualified by rx_valid
break_detect  output  1  all data, parity and stop bits were 0; qualified by rx_valid
busy  output  1  state is not IDLE

Behaviour:
- Reset values:
  - all outputs 0
  - synchroniser flops 1
  - state IDLE
  - tick counter 0
  - shift register 0
- Synchroniser: uart_rx passes through SYNC_STAGES flops; all logic below uses the synchronised value rxs.
- Timing base:
  - All state and counter advances happen only on clk edges where baud_tick=1.
  - tcnt is 4 bits and wraps 15->0.
- Bit decision:
  - rxs is sampled when tcnt=7, 8 and 9.
  - The bit value is the 2-of-3 majority of those samples.
  - The decision is taken on the tick where tcnt=9.
- State machine (IDLE, START, DATA, PARITY, STOP1, STOP2, WAIT_HIGH):
  - IDLE: on a tick with rxs=0, set tcnt=0 and go to START.
  - START: at the tcnt=9 decision, a majority of 1 is a glitch and goes to IDLE with no output. A majority of 0 continues; at tcnt=15 go to DATA with bit index 0.
  - DATA: the decided bit is shifted in LSB first. After bit (data_bits+5)-1 ends (tcnt=15), go to PARITY if parity is enabled, otherwise STOP1.
  - PARITY: the decided bit is compared with the expected value. Even mode expects XOR(data) ^ p = 0; odd mode expects it to be 1. A mismatch sets the internal parity flag. At tcnt=15 go to STOP1.
  - STOP1: at the tcnt=9 decision, a value of 0 sets the frame flag.
    - two_stop=1 and the bit was 1: wait for tcnt=15, then go to STOP2.
    - Otherwise the frame completes.
  - STOP2: the decision is made at tcnt=9 and the frame completes.
- Frame completion:
  - rx_valid=1 for exactly one clk cycle, on the clk cycle after the completing tick.
  - rx_data, parity_error, frame_error and break_detect are registered at the same time and hold until the next completion.
  - Next state is IDLE when the final stop bit is 1, otherwise WAIT_HIGH.
  - A stop bit decided early (at tcnt=9) allows a back-to-back start edge to be caught.
- break_detect: 1 when every data bit, the parity bit (if enabled) and STOP1 are all 0. frame_error is always 1 with it.
- WAIT_HIGH: stay until a tick with rxs=1, then go to IDLE. No new frames are accepted during a break.
- Configuration: data_bits, parity_mode and two_stop are captured on entering START. Changes during a frame take effect on the next frame.
- enable=0: state goes to IDLE and tcnt clears on the next clk. A partial frame is discarded and no rx_valid is produced. Registered outputs keep their last values, except rx_valid=0.
- rx_valid is never asserted twice for one frame. There is no backpressure; FIFO overflow is handled by the FIFO.

Test Plan:
1. 8N1, drive 0xA5 at 16 ticks per bit -> exactly one rx_valid, rx_data=0xA5, all error flags 0, busy=0 after completion.
2. 7E1, drive 0x41 with parity bit 1 (wrong) -> rx_data=0x41, parity_error=1. Repeat with parity bit 0 -> parity_error=0. Repeat 7O1 with parity 1 -> parity_error=0.
3. 8N2, drive 0x3C with STOP2=0 -> rx_data=0x3C, frame_error=1, break_detect=0; state reaches WAIT_HIGH and a following 0x55 frame is received cleanly.
4. 8E1, hold line low for 20 bit times -> one rx_valid, rx_data=0x00, frame_error=1, break_detect=1; no further strobes until the line returns high.
5. Start glitch low for 4 ticks, then 1 tick of noise inside a data bit at tcnt=8 -> glitch gives no output; noise is voted out by majority and the byte is correct.
6. Two back-to-back 8N1 frames 0x12, 0x34 with no idle gap; then deassert enable mid-third frame -> two strobes with correct data; no strobe for the aborted frame; busy=0 one clk after enable falls.

Source files
------------

// File: rtl/uart_rx_core.sv
// uart_rx_core: 16x oversampled UART receive engine. It votes 2-of-3 around
// mid-bit, deframes data/parity/stop bits and strobes each character out.
module uart_rx_core #(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       baud_tick,
    input  logic       uart_rx,
    input  logic [1:0] data_bits,
    input  logic [1:0] parity_mode,
    input  logic       two_stop,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       parity_error,
    output logic       frame_error,
    output logic       break_detect,
    output logic       busy
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP1     = 3'd4,
        ST_STOP2     = 3'd5,
        ST_WAIT_HIGH = 3'd6
    } state_t;

    localparam logic [3:0] TCNT_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] TCNT_S0   = 4'd7;
    localparam logic [3:0] TCNT_S1   = 4'd8;
    localparam logic [3:0] TCNT_DEC  = 4'd9;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic xor8(input logic [7:0] d);
        return ^d;
    endfunction

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   rxs_s;
    state_t                 state_r;
    logic [3:0]             tcnt_r;
    logic [2:0]             bit_idx_r;
    logic [7:0]             shift_r;
    logic                   samp_a_r;
    logic                   samp_b_r;
    logic [1:0]             cfg_bits_r;
    logic [1:0]             cfg_parity_r;
    logic                   cfg_two_r;
    logic                   par_flag_r;
    logic                   par_zero_r;

    logic                   bit_val_s;
    logic                   decide_s;
    logic                   at_last_s;
    logic [2:0]             last_idx_s;
    logic                   par_en_s;
    logic                   par_odd_s;

    assign rxs_s      = sync_r[SYNC_STAGES-1];
    assign bit_val_s  = maj3(samp_a_r, samp_b_r, rxs_s);
    assign decide_s   = (tcnt_r == TCNT_DEC);
    assign at_last_s  = (tcnt_r == TCNT_LAST);
    assign last_idx_s = {1'b0, cfg_bits_r} + 3'd4;
    assign par_en_s   = cfg_parity_r[0] ^ cfg_parity_r[1];
    assign par_odd_s  = (cfg_parity_r == 2'b10);

    // Metastability synchroniser for the serial line, idles high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_r <= '1;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], uart_rx};
        end
    end

    // Receive FSM: tick counter, bit voting, deframing and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            tcnt_r       <= 4'd0;
            bit_idx_r    <= 3'd0;
            shift_r      <= 8'd0;
            samp_a_r     <= 1'b0;
            samp_b_r     <= 1'b0;
            cfg_bits_r   <= 2'd0;
            cfg_parity_r <= 2'd0;
            cfg_two_r    <= 1'b0;
            par_flag_r   <= 1'b0;
            par_zero_r   <= 1'b0;
            rx_data      <= 8'd0;
            rx_valid     <= 1'b0;
            parity_error <= 1'b0;
            frame_error  <= 1'b0;
            break_detect <= 1'b0;
            busy         <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (!enable) begin
                state_r <= ST_IDLE;
                tcnt_r  <= 4'd0;
                busy    <= 1'b0;
            end else if (baud_tick) begin
                if (state_r != ST_IDLE) begin
                    tcnt_r <= tcnt_r + 4'd1;
                end
                if (tcnt_r == TCNT_S0) begin
                    samp_a_r <= rxs_s;
                end
                if (tcnt_r == TCNT_S1) begin
                    samp_b_r <= rxs_s;
                end
                case (state_r)
                    ST_IDLE: begin
                        if (!rxs_s) begin
                            state_r      <= ST_START;
                            busy         <= 1'b1;
                            tcnt_r       <= 4'd0;
                            shift_r      <= 8'd0;
                            par_flag_r   <= 1'b0;
                            par_zero_r   <= 1'b1;
                            cfg_bits_r   <= data_bits;
                            cfg_parity_r <= parity_mode;
                            cfg_two_r    <= two_stop;
                        end
                    end
                    ST_START: begin
                        if (decide_s && bit_val_s) begin
                            state_r <= ST_IDLE;
                            busy    <= 1'b0;
                        end else if (at_last_s) begin
                            state_r   <= ST_DATA;
                            bit_idx_r <= 3'd0;
                        end
                    end
                    ST_DATA: begin
                        if (decide_s) begin
                            shift_r[bit_idx_r] <= bit_val_s;
                        end
                        if (at_last_s) begin
                            if (bit_idx_r == last_idx_s) begin
                                state_r <= par_en_s ? ST_PARITY : ST_STOP1;
                            end else begin
                                bit_idx_r <= bit_idx_r + 3'd1;
                            end
                        end
                    end
                    ST_PARITY: begin
                        if (decide_s) begin
                            par_flag_r <= (xor8(shift_r) ^ bit_val_s) != par_odd_s;
                            par_zero_r <= ~bit_val_s;
                        end
                        if (at_last_s) begin
                            state_r <= ST_STOP1;
                        end
                    end
                    ST_STOP1: begin
                        // A good first stop with two_stop set waits for STOP2;
                        // anything else completes early so a back-to-back start is seen.
                        if (decide_s && !(cfg_two_r && bit_val_s)) begin
                            rx_valid     <= 1'b1;
                            rx_data      <= shift_r;
                            parity_error <= par_flag_r;
                            frame_error  <= ~bit_val_s;
                            break_detect <= (shift_r == 8'd0) && par_zero_r && !bit_val_s;
                            state_r      <= bit_val_s ? ST_IDLE : ST_WAIT_HIGH;
                            busy         <= ~bit_val_s;
                        end else if (at_last_s) begin
                            state_r <= ST_STOP2;
                        end
                    end
                    ST_STOP2: begin
                        if (decide_s) begin
                            rx_valid     <= 1'b1;
                            rx_data      <= shift_r;
                            parity_error <= par_flag_r;
                            frame_error  <= ~bit_val_s;
                            break_detect <= 1'b0;
                            state_r      <= bit_val_s ? ST_IDLE : ST_WAIT_HIGH;
                            busy         <= ~bit_val_s;
                        end
                    end
                    ST_WAIT_HIGH: begin
                        if (rxs_s) begin
                            state_r <= ST_IDLE;
                            busy    <= 1'b0;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: serial frames are driven on baud-tick
// boundaries and received characters are checked against a scoreboard queue.
module tb_uart_rx_core;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        logic       bd;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       baud_tick;
    logic       uart_rx;
    logic [1:0] data_bits;
    logic [1:0] parity_mode;
    logic       two_stop;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_error;
    logic       frame_error;
    logic       break_detect;
    logic       busy;

    exp_t sb[$];
    int   tests   = 0;
    int   fails   = 0;
    int   strobes = 0;
    int   tick_cnt = 0;
    int   snap;

    uart_rx_core dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .baud_tick    (baud_tick),
        .uart_rx      (uart_rx),
        .data_bits    (data_bits),
        .parity_mode  (parity_mode),
        .two_stop     (two_stop),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .parity_error (parity_error),
        .frame_error  (frame_error),
        .break_detect (break_detect),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // 16x tick: one clk in four.
    initial begin
        baud_tick = 1'b0;
        forever begin
            @(negedge clk);
            baud_tick = (tick_cnt == 0);
            tick_cnt  = (tick_cnt + 1) % 4;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_char(input logic [7:0] d, input logic pe, input logic fe, input logic bd);
        exp_t e;
        e.d  = d;
        e.pe = pe;
        e.fe = fe;
        e.bd = bd;
        sb.push_back(e);
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!baud_tick) @(posedge clk);
        end
    endtask

    task automatic send_bit(input logic b, input int n);
        uart_rx = b;
        wait_ticks(n);
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input int nb, input int pbit,
                              input logic s1, input logic s2, input int nstop, input int noise_bit);
        send_bit(1'b0, 16);
        for (int i = 0; i < nb; i++) begin
            if (i == noise_bit) begin
                send_bit(d[i], 8);
                send_bit(~d[i], 1);
                send_bit(d[i], 7);
            end else begin
                send_bit(d[i], 16);
            end
        end
        if (pbit >= 0) send_bit(pbit[0], 16);
        send_bit(s1, 16);
        if (nstop == 2) send_bit(s2, 16);
    endtask

    // Output monitor: every strobe pops one expected character.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rx_valid) begin
                strobes++;
                check("strobe_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("rx_data", 32'(rx_data), 32'(e.d));
                    check("parity_error", 32'(parity_error), 32'(e.pe));
                    check("frame_error", 32'(frame_error), 32'(e.fe));
                    check("break_detect", 32'(break_detect), 32'(e.bd));
                end
            end
        end
    end

    initial begin
        reset       = 1'b1;
        enable      = 1'b0;
        uart_rx     = 1'b1;
        data_bits   = 2'b11;
        parity_mode = 2'b00;
        two_stop    = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_rx_data", 32'(rx_data), 32'd0);
        check("reset_rx_valid", 32'(rx_valid), 32'd0);
        check("reset_flags", 32'({parity_error, frame_error, break_detect}), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        reset  = 1'b0;
        enable = 1'b1;
        wait_ticks(1);
        @(negedge clk);
        send_bit(1'b1, 32);

        // 8N1 0xA5
        expect_char(8'hA5, 1'b0, 1'b0, 1'b0);
        send_frame(8'hA5, 8, -1, 1'b1, 1'b1, 1, -1);
        send_bit(1'b1, 32);
        check("t1_busy_idle", 32'(busy), 32'd0);
        check("t1_strobes", 32'(strobes), 32'd1);

        // 7E1 / 7O1 parity variants on 0x41
        data_bits   = 2'b10;
        parity_mode = 2'b01;
        expect_char(8'h41, 1'b1, 1'b0, 1'b0);
        send_frame(8'h41, 7, 1, 1'b1, 1'b1, 1, -1);
        send_bit(1'b1, 32);
        expect_char(8'h41, 1'b0, 1'b0, 1'b0);
        send_frame(8'h41, 7, 0, 1'b1, 1'b1, 1, -1);
        send_bit(1'b1, 32);
        parity_mode = 2'b10;
        expect_char(8'h41, 1'b0, 1'b0, 1'b0);
        send_frame(8'h41, 7, 1, 1'b1, 1'b1, 1, -1);
        send_bit(1'b1, 32);
        check("t2_strobes", 32'(strobes), 32'd4);

        // 8N2 with bad STOP2, then a clean frame
        data_bits   = 2'b11;
        parity_mode = 2'b00;
        two_stop    = 1'b1;
        expect_char(8'h3C, 1'b0, 1'b1, 1'b0);
        send_frame(8'h3C, 8, -1, 1'b1, 1'b0, 2, -1);
        check("t3_wait_high_busy", 32'(busy), 32'd1);
        send_bit(1'b1, 32);
        check("t3_idle_busy", 32'(busy), 32'd0);
        expect_char(8'h55, 1'b0, 1'b0, 1'b0);
        send_frame(8'h55, 8, -1, 1'b1, 1'b1, 2, -1);
        send_bit(1'b1, 32);
        check("t3_strobes", 32'(strobes), 32'd6);

        // 8E1 break: line low for 20 bit times
        two_stop    = 1'b0;
        parity_mode = 2'b01;
        expect_char(8'h00, 1'b0, 1'b1, 1'b1);
        send_bit(1'b0, 320);
        check("t4_break_busy", 32'(busy), 32'd1);
        check("t4_one_strobe", 32'(strobes), 32'd7);
        send_bit(1'b1, 32);
        check("t4_after_break_busy", 32'(busy), 32'd0);

        // Start glitch, then a byte with one tick of noise at mid-bit
        parity_mode = 2'b00;
        snap = strobes;
        send_bit(1'b0, 4);
        send_bit(1'b1, 40);
        check("t5_glitch_no_strobe", 32'(strobes), 32'(snap));
        check("t5_glitch_busy", 32'(busy), 32'd0);
        expect_char(8'hC3, 1'b0, 1'b0, 1'b0);
        send_frame(8'hC3, 8, -1, 1'b1, 1'b1, 1, 2);
        send_bit(1'b1, 32);
        check("t5_strobes", 32'(strobes), 32'(snap + 1));

        // Back-to-back frames, then abort a third one
        snap = strobes;
        expect_char(8'h12, 1'b0, 1'b0, 1'b0);
        expect_char(8'h34, 1'b0, 1'b0, 1'b0);
        send_frame(8'h12, 8, -1, 1'b1, 1'b1, 1, -1);
        send_frame(8'h34, 8, -1, 1'b1, 1'b1, 1, -1);
        send_bit(1'b0, 16);
        send_bit(1'b0, 16);
        send_bit(1'b1, 16);
        send_bit(1'b1, 16);
        check("t6_mid_frame_busy", 32'(busy), 32'd1);
        enable = 1'b0;
        @(posedge clk);
        #1;
        check("t6_abort_busy", 32'(busy), 32'd0);
        @(negedge clk);
        uart_rx = 1'b1;
        send_bit(1'b1, 48);
        enable = 1'b1;
        send_bit(1'b1, 48);
        check("t6_strobes", 32'(strobes), 32'(snap + 2));
        check("t6_rx_valid_low", 32'(rx_valid), 32'd0);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
